cache_ctrl: RTL
===============

CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk (rising edge) and reset_n (active-high despite its name; it keeps the codebase's existing port name).
REQ-002 clk  in  1  system clock.
REQ-003 reset_n  in  1  asynchronous reset, active-high.
REQ-004 cpu_req  in  1  request strobe, sampled only in IDLE.
REQ-005 cpu_we  in  1  1 = write, 0 = read; captured with cpu_req.
REQ-006 cpu_addr  in  14  byte address: tag/index [13:6], line offset [5:0].
REQ-007 cpu_ready  out  1  one-cycle completion pulse.
REQ-008 cpu_hit  out  1  lookup result, valid only while cpu_ready=1.
REQ-009 busy  out  1  high whenever state is not IDLE.
REQ-010 tm_addr  out  14  address to tag_mem, equal to the captured request address.
REQ-011 tm_wr  out  1  tag_mem allocate strobe.
REQ-012 tm_md  out  1  tag_mem modify/touch strobe.
REQ-013 tm_hit  in  1  tag_mem hit, valid one cycle after tm_addr is stable.
REQ-014 tm_chan  in  3  tag_mem hit way (0..7).
REQ-015 mem_req, mem_we  out  1 each  backing-memory request and direction.
REQ-016 mem_addr  out  14  backing-memory address.
REQ-017 mem_ack  in  1  backing-memory completion, sampled on clk.

Function
REQ-018 FSM states SHALL be IDLE, LOOKUP, CHECK, FILL, TAG_WR, WT and RESP; all outputs are registered.
REQ-019 In IDLE with cpu_req=1, the block SHALL capture cpu_addr and cpu_we, then go to LOOKUP; input changes are ignored until RESP completes.
REQ-020 LOOKUP SHALL last exactly 1 cycle, for tag_mem settling, then go to CHECK, where tm_hit and tm_chan are sampled.
REQ-021 CHECK transitions SHALL be: read hit -> RESP (cpu_hit=1); read miss -> FILL; write hit -> tm_md=1 for exactly 1 cycle, then WT; write miss -> WT with no allocate (cpu_hit=0).
REQ-022 In FILL, the block SHALL hold mem_req=1, mem_we=0 and mem_addr={addr[13:6],6'b0} until mem_ack=1 is sampled, then go to TAG_WR; mem_ack in the first FILL cycle is legal.
REQ-023 TAG_WR SHALL assert tm_wr=1 for exactly 1 cycle, then go to RESP with cpu_hit=0.
REQ-024 In WT, the block SHALL hold mem_req=1, mem_we=1 and mem_addr=full captured address until mem_ack=1 is sampled, then go to RESP.
REQ-025 mem_req SHALL drop in the cycle after mem_ack is sampled; mem_ack outside FILL/WT is ignored.
REQ-026 RESP SHALL assert cpu_ready=1 for 1 cycle and then return to IDLE; cpu_req during RESP is not accepted.
REQ-027 Read-hit latency SHALL be: cpu_ready high in the 3rd cycle after the accepting edge; back-to-back requests SHALL have a minimum spacing of 4 cycles.
REQ-028 tm_wr and tm_md SHALL never be high in the same cycle, and each SHALL pulse at most once per request.
REQ-029 If mem_ack never arrives, the block SHALL stay in FILL/WT with mem_req held; it has no timeout.

Reset
REQ-030 While reset_n=1, the block SHALL immediately force state IDLE, all outputs 0, the captured address/we to 0, and the counters to 0.
REQ-031 Reset during FILL or WT SHALL drop mem_req asynchronously; the aborted request SHALL produce no tm_wr pulse and no cpu_ready.

Configuration
REQ-032 With macro CACHE_CTRL_STATS_EN defined, the block SHALL add outputs hit_cnt[15:0] and miss_cnt[15:0], each incremented once per request in CHECK, saturating at 16'hFFFF and cleared by reset.
REQ-033 Without CACHE_CTRL_STATS_EN, these ports and the counter logic SHALL be absent; all other behaviour is identical.

Verification
REQ-034 Read miss at 14'h0040, mem_ack 2 cycles after mem_req -> mem_addr=14'h0040, one tm_wr pulse, cpu_ready with cpu_hit=0.
REQ-035 Repeat read at 14'h0047 after REQ-034 (tag_mem reports hit) -> no mem_req, cpu_ready exactly 3 cycles after acceptance, cpu_hit=1.
REQ-036 Write hit at 14'h0045 -> one tm_md pulse, then mem_req=1, mem_we=1, mem_addr=14'h0045, and cpu_ready after mem_ack; tm_wr stays 0.
REQ-037 Write miss at 14'h0300 -> no tm_wr and no tm_md, write-through to 14'h0300, cpu_hit=0.
REQ-038 reset_n pulsed high in the 3rd FILL cycle -> mem_req=0 in the same cycle, busy=0, no cpu_ready; a new read afterwards completes normally.
REQ-039 With CACHE_CTRL_STATS_EN defined: 3 hits and 2 misses -> hit_cnt=3, miss_cnt=2; with the counter preloaded at 16'hFFFF, a further hit leaves hit_cnt=16'hFFFF.

Source files
------------

// File: rtl/cache_ctrl.sv
// cache_ctrl: request sequencer for a tag_mem-based cache with read-allocate fills and write-through.
// Define CACHE_CTRL_STATS_EN to add saturating hit_cnt/miss_cnt statistics outputs.
module cache_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [13:0] cpu_addr,
    output logic        cpu_ready,
    output logic        cpu_hit,
    output logic        busy,
    output logic [13:0] tm_addr,
    output logic        tm_wr,
    output logic        tm_md,
    input  logic        tm_hit,
    input  logic [2:0]  tm_chan,
    output logic        mem_req,
    output logic        mem_we,
    output logic [13:0] mem_addr,
    input  logic        mem_ack
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        CHECK,
        FILL,
        TAG_WR,
        WT,
        RESP
    } state_t;

    state_t      state, state_nxt;
    logic [13:0] addr, addr_nxt;
    logic        we, we_nxt;
    logic        hit, hit_nxt;
    logic        cpu_ready_nxt, cpu_hit_nxt;
    logic        tm_wr_nxt, tm_md_nxt;
    logic        mem_req_nxt, mem_we_nxt;
    logic [13:0] mem_addr_nxt;

    // The hit way is not needed to sequence a request; tag_mem tracks it itself.
    logic unused_chan;
    assign unused_chan = ^tm_chan;

    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr;
        we_nxt        = we;
        hit_nxt       = hit;
        cpu_ready_nxt = 1'b0;
        cpu_hit_nxt   = 1'b0;
        tm_wr_nxt     = 1'b0;
        tm_md_nxt     = 1'b0;
        mem_req_nxt   = 1'b0;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;

        case (state)
            IDLE: begin
                if (cpu_req) begin
                    addr_nxt  = cpu_addr;
                    we_nxt    = cpu_we;
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                state_nxt = CHECK;
            end
            CHECK: begin
                hit_nxt = tm_hit;
                if (!we && tm_hit) begin
                    state_nxt     = RESP;
                    cpu_ready_nxt = 1'b1;
                    cpu_hit_nxt   = 1'b1;
                end else if (!we) begin
                    state_nxt    = FILL;
                    mem_req_nxt  = 1'b1;
                    mem_we_nxt   = 1'b0;
                    mem_addr_nxt = {addr[13:6], 6'b0};
                end else if (tm_hit) begin
                    // Touch the line first; the write-through starts on the following cycle.
                    state_nxt = WT;
                    tm_md_nxt = 1'b1;
                end else begin
                    state_nxt    = WT;
                    mem_req_nxt  = 1'b1;
                    mem_we_nxt   = 1'b1;
                    mem_addr_nxt = addr;
                end
            end
            FILL: begin
                if (mem_ack) begin
                    state_nxt = TAG_WR;
                    tm_wr_nxt = 1'b1;
                end else begin
                    mem_req_nxt = 1'b1;
                end
            end
            TAG_WR: begin
                state_nxt     = RESP;
                cpu_ready_nxt = 1'b1;
            end
            WT: begin
                if (tm_md) begin
                    mem_req_nxt  = 1'b1;
                    mem_we_nxt   = 1'b1;
                    mem_addr_nxt = addr;
                end else if (mem_ack) begin
                    state_nxt     = RESP;
                    cpu_ready_nxt = 1'b1;
                    cpu_hit_nxt   = hit;
                end else begin
                    mem_req_nxt = 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state     <= IDLE;
            addr      <= '0;
            we        <= 1'b0;
            hit       <= 1'b0;
            cpu_ready <= 1'b0;
            cpu_hit   <= 1'b0;
            busy      <= 1'b0;
            tm_addr   <= '0;
            tm_wr     <= 1'b0;
            tm_md     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
        end else begin
            state     <= state_nxt;
            addr      <= addr_nxt;
            we        <= we_nxt;
            hit       <= hit_nxt;
            cpu_ready <= cpu_ready_nxt;
            cpu_hit   <= cpu_hit_nxt;
            busy      <= (state_nxt != IDLE);
            tm_addr   <= addr_nxt;
            tm_wr     <= tm_wr_nxt;
            tm_md     <= tm_md_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == CHECK) begin
            if (tm_hit) begin
                hit_cnt <= sat_inc(hit_cnt);
            end else begin
                miss_cnt <= sat_inc(miss_cnt);
            end
        end
    end
`endif

endmodule
